// File: rtl/seg_pkg.sv
// Shared types and constants for the seven-segment scan controller.
package seg_pkg;
    localparam int N_DIG = 8;

    typedef logic [3:0] hex_t;
    typedef logic [2:0] sel_t;

    typedef struct packed {
        logic dp;
        hex_t val;
    } digit_t;
endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Write-port and display-side signal bundle for seg_scan_ctrl.
interface seg_scan_ctrl_if;
    import seg_pkg::*;

    logic             wr_en;
    sel_t             wr_addr;
    hex_t             wr_data;
    logic             wr_dp;
    logic             commit;
    logic [N_DIG-1:0] dig_mask;
    hex_t             digit_o;
    sel_t             sel_o;
    logic             dp_o;
    logic             blank_o;
    logic             frame_o;

    modport master (
        output wr_en, wr_addr, wr_data, wr_dp, commit, dig_mask,
        input  digit_o, sel_o, dp_o, blank_o, frame_o
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, wr_dp, commit, dig_mask,
        output digit_o, sel_o, dp_o, blank_o, frame_o
    );
endinterface

// File: rtl/seg_slot_timer.sv
// Slot timer: divides clk into digit slots and steps the slot index 0..7.
module seg_slot_timer
    import seg_pkg::*;
#(
    parameter int CLK_DIV   = 100000,
    parameter int BLANK_CYC = 1000
) (
    input  logic clk,
    input  logic rst_n,
    output sel_t slot,
    output logic cnt_lt_blank,
    output logic wrap
);
    localparam int CNT_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] r_cnt;
    sel_t             r_slot;
    logic             w_slot_end;

    assign w_slot_end = (r_cnt == CNT_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_slot <= '0;
        end else if (w_slot_end) begin
            r_cnt  <= '0;
            r_slot <= r_slot + 3'd1;
        end else begin
            r_cnt  <= r_cnt + 1'b1;
        end
    end

    // Signed int compare so BLANK_CYC = 0 simply never blanks.
    assign cnt_lt_blank = (int'(r_cnt) < BLANK_CYC);
    assign wrap         = w_slot_end && (r_slot == sel_t'(N_DIG - 1));
    assign slot         = r_slot;
endmodule

// File: rtl/seg_scan_ctrl.sv
// Double-buffered 8-digit scan controller feeding the hex/anode decoder.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int CLK_DIV   = 100000,
    parameter int BLANK_CYC = 1000
) (
    input  logic            clk,
    input  logic            rst_n,
    seg_scan_ctrl_if.slave  bus
);
    digit_t r_shadow [N_DIG];
    digit_t r_active [N_DIG];
    logic   r_pending;
    logic   r_frame;

    sel_t   w_slot;
    logic   w_cnt_lt_blank;
    logic   w_wrap;
    logic   w_copy;
    digit_t w_cur;

    seg_slot_timer #(
        .CLK_DIV   (CLK_DIV),
        .BLANK_CYC (BLANK_CYC)
    ) u_timer (
        .clk          (clk),
        .rst_n        (rst_n),
        .slot         (w_slot),
        .cnt_lt_blank (w_cnt_lt_blank),
        .wrap         (w_wrap)
    );

    // A commit in the wrap cycle itself still lands at this wrap.
    assign w_copy = w_wrap && (r_pending || bus.commit);

    genvar gi;
    generate
        for (gi = 0; gi < N_DIG; gi++) begin : g_dig
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_shadow[gi] <= '0;
                end else if (bus.wr_en && (bus.wr_addr == sel_t'(gi))) begin
                    r_shadow[gi] <= '{dp: bus.wr_dp, val: bus.wr_data};
                end
            end

            // Copies the pre-edge shadow, so a same-cycle write waits for the next commit.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_active[gi] <= '0;
                end else if (w_copy) begin
                    r_active[gi] <= r_shadow[gi];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending <= 1'b0;
            r_frame   <= 1'b0;
        end else begin
            r_frame <= w_wrap;
            if (w_copy) begin
                r_pending <= 1'b0;
            end else if (bus.commit) begin
                r_pending <= 1'b1;
            end
        end
    end

    assign w_cur       = r_active[w_slot];
    assign bus.sel_o   = w_slot;
    assign bus.digit_o = w_cur.val;
    assign bus.dp_o    = w_cur.dp;
    assign bus.frame_o = r_frame;
    // dig_mask is deliberately live so a digit can be masked without waiting a frame.
    assign bus.blank_o = w_cnt_lt_blank || !bus.dig_mask[w_slot];
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with CLK_DIV=4, BLANK_CYC=1.
module tb_seg_scan_ctrl;
    logic clk;
    logic rst_n;

    seg_scan_ctrl_if bus ();

    seg_scan_ctrl #(
        .CLK_DIV   (4),
        .BLANK_CYC (1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int n     = 0;
    logic [3:0] exp_val [8];
    logic       exp_dp  [8];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s (cycle %0d): got %0h expected %0h", tag, n, obs, exp);
        end
    endtask

    // Expected state at cycle n after reset release: slot = n/4 mod 8, cnt = n mod 4.
    task automatic cyc(input string tag);
        logic [2:0] s;
        int         c;
        s = 3'((n / 4) % 8);
        c = n % 4;
        chk({tag, ".sel"},   32'(bus.sel_o),   32'(s));
        chk({tag, ".digit"}, 32'(bus.digit_o), 32'(exp_val[s]));
        chk({tag, ".dp"},    32'(bus.dp_o),    32'(exp_dp[s]));
        chk({tag, ".frame"}, 32'(bus.frame_o), 32'((n % 32 == 0) && (n > 0)));
        chk({tag, ".blank"}, 32'(bus.blank_o), 32'((c == 0) || !bus.dig_mask[s]));
    endtask

    task automatic tick(input string tag);
        cyc(tag);
        @(negedge clk);
        n++;
    endtask

    task automatic go_to(input string tag, input int phase);
        for (int k = 0; k < 32 && (n % 32) != phase; k++) tick(tag);
    endtask

    task automatic do_write(input string tag, input logic [2:0] a, input logic [3:0] d, input logic dp);
        $display("write  addr=%0d data=%0h dp=%0d at cycle %0d", a, d, dp, n);
        bus.wr_en = 1'b1; bus.wr_addr = a; bus.wr_data = d; bus.wr_dp = dp;
        tick(tag);
        bus.wr_en = 1'b0;
    endtask

    task automatic do_commit(input string tag);
        $display("commit at cycle %0d", n);
        bus.commit = 1'b1;
        tick(tag);
        bus.commit = 1'b0;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ".sel"},   32'(bus.sel_o),   32'd0);
        chk({tag, ".digit"}, 32'(bus.digit_o), 32'd0);
        chk({tag, ".dp"},    32'(bus.dp_o),    32'd0);
        chk({tag, ".blank"}, 32'(bus.blank_o), 32'd1);
        chk({tag, ".frame"}, 32'(bus.frame_o), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0; bus.wr_dp = 1'b0;
        bus.commit = 1'b0; bus.dig_mask = 8'hFF;
        for (int i = 0; i < 8; i++) begin exp_val[i] = 4'h0; exp_dp[i] = 1'b0; end

        repeat (3) @(negedge clk);
        chk_reset("rst");
        rst_n = 1'b1;
        n = 0;

        // Free-running scan from reset release.
        repeat (40) tick("scan");

        // Shadow write alone must never reach the display.
        do_write("nocommit", 3'd2, 4'hA, 1'b0);
        repeat (64) tick("nocommit");

        // Write plus mid-frame commit takes effect at the next wrap.
        do_write("commit", 3'd2, 4'hA, 1'b1);
        go_to("commit", 12);
        do_commit("commit");
        go_to("commit", 0);
        exp_val[2] = 4'hA; exp_dp[2] = 1'b1;
        repeat (32) tick("commit_new");

        // Write and commit in the wrap cycle: old shadow copied, new write held back.
        do_write("wrapw", 3'd0, 4'h5, 1'b0);
        go_to("wrapw", 31);
        $display("write  addr=1 data=7 dp=0 with commit in wrap cycle %0d", n);
        bus.wr_en = 1'b1; bus.wr_addr = 3'd1; bus.wr_data = 4'h7; bus.wr_dp = 1'b0;
        bus.commit = 1'b1;
        tick("wrapw");
        bus.wr_en = 1'b0; bus.commit = 1'b0;
        exp_val[0] = 4'h5;
        repeat (32) tick("wrapw_after");
        do_commit("wrapw2");
        go_to("wrapw2", 0);
        exp_val[1] = 4'h7;
        repeat (32) tick("wrapw2_after");

        // Live digit mask.
        $display("dig_mask=FE at cycle %0d", n);
        bus.dig_mask = 8'hFE;
        #1;
        chk("mask.live", 32'(bus.blank_o), 32'd1);
        repeat (32) tick("mask");
        bus.dig_mask = 8'hFF;
        #1;

        // Reset mid-frame with a commit pending.
        do_write("midrst", 3'd5, 4'h9, 1'b1);
        go_to("midrst", 12);
        do_commit("midrst");
        go_to("midrst", 21);
        $display("reset asserted at cycle %0d, sel_o=%0d", n, bus.sel_o);
        chk("midrst.presel", 32'(bus.sel_o), 32'd5);
        rst_n = 1'b0;
        #1;
        chk_reset("midrst.now");
        repeat (2) @(negedge clk);
        chk_reset("midrst.hold");
        rst_n = 1'b1;
        n = 0;
        for (int i = 0; i < 8; i++) begin exp_val[i] = 4'h0; exp_dp[i] = 1'b0; end
        repeat (34) tick("post_rst");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
